// File: rtl/maroc_sc_scheduler_if.sv
// Bundle between the slow-control scheduler, its requesters and the shared MAROC transmitter.
// The scheduler side uses the slave modport; the requester/transmitter side uses master.
interface maroc_sc_scheduler_if #(
  parameter int NREQ = 4,
  parameter int SELW = 2
);
  logic [NREQ-1:0] req_in;
  logic [NREQ-1:0] grant_out;
  logic [SELW-1:0] sel_out;
  logic [NREQ-1:0] done_out;
  logic            err_out;
  logic            busy_out;
  logic [7:0]      err_cnt_out;
  logic            tx_start_out;
  logic            tx_reset_out;
  logic [1:0]      tx_state_in;

  modport slave (
    input  req_in,
    input  tx_state_in,
    output grant_out,
    output sel_out,
    output done_out,
    output err_out,
    output busy_out,
    output err_cnt_out,
    output tx_start_out,
    output tx_reset_out
  );

  modport master (
    output req_in,
    output tx_state_in,
    input  grant_out,
    input  sel_out,
    input  done_out,
    input  err_out,
    input  busy_out,
    input  err_cnt_out,
    input  tx_start_out,
    input  tx_reset_out
  );
endinterface

// File: rtl/maroc_sc_scheduler.sv
// Round-robin arbiter and sequencer for the shared MAROC slow-control transmitter:
// grants one requester, pulses start, tracks the transmitter state and recovers it on timeout.
module maroc_sc_scheduler #(
  parameter int NREQ       = 4,
  parameter int SELW       = 2,
  parameter int TIMEOUT    = 1100,
  parameter int RST_CYCLES = 4
) (
  input  logic                    clk_in,
  input  logic                    rstn_in,
  maroc_sc_scheduler_if.slave     bus
);

  localparam int RCW = $clog2(RST_CYCLES + 1);

  localparam logic [1:0] TX_IDLE    = 2'd0;
  localparam logic [1:0] TX_SENDING = 2'd2;
  localparam logic [1:0] TX_FINAL   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_SEND,
    S_WAIT_FINAL,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [SELW-1:0] sel_q;
  logic [SELW-1:0] last_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic            busy_q;
  logic [7:0]      err_cnt_q;
  logic            tx_start_q;
  logic            tx_reset_q;
  logic [10:0]     tmo_q;
  logic [RCW-1:0]  rcnt_q;

  logic            pick_valid;
  logic [SELW-1:0] pick_idx;
  logic [SELW-1:0] scan_idx;
  logic            tx_ready;
  logic            tmo_hit;

  // Scan downward in distance so the nearest requester after last_q wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      scan_idx = SELW'((int'(last_q) + i) % NREQ);
      if (bus.req_in[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign tx_ready = (bus.tx_state_in == TX_IDLE) || (bus.tx_state_in == TX_FINAL);
  assign tmo_hit  = (tmo_q == 11'(TIMEOUT - 1));

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      last_q     <= SELW'(NREQ - 1);
      done_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      err_cnt_q  <= '0;
      tx_start_q <= 1'b0;
      tx_reset_q <= 1'b0;
      tmo_q      <= '0;
      rcnt_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      done_q     <= '0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (pick_valid && tx_ready) begin
            grant_q    <= NREQ'(1) << pick_idx;
            sel_q      <= pick_idx;
            last_q     <= pick_idx;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end

        S_START: begin
          tmo_q   <= '0;
          state_q <= S_WAIT_SEND;
        end

        S_WAIT_SEND: begin
          tmo_q <= tmo_q + 11'd1;
          if (bus.tx_state_in == TX_SENDING) begin
            state_q <= S_WAIT_FINAL;
          end else if (tmo_hit) begin
            tx_reset_q <= 1'b1;
            rcnt_q     <= '0;
            state_q    <= S_RECOVER;
          end
        end

        S_WAIT_FINAL: begin
          tmo_q <= tmo_q + 11'd1;
          if (bus.tx_state_in == TX_FINAL) begin
            done_q  <= grant_q;
            state_q <= S_DONE;
          end else if (bus.tx_state_in == TX_IDLE) begin
            // Transmitter was reset by someone else: report failure, no recovery needed.
            done_q  <= grant_q;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else if (tmo_hit) begin
            tx_reset_q <= 1'b1;
            rcnt_q     <= '0;
            state_q    <= S_RECOVER;
          end
        end

        S_RECOVER: begin
          rcnt_q <= rcnt_q + RCW'(1);
          if (rcnt_q == RCW'(RST_CYCLES - 1)) begin
            tx_reset_q <= 1'b0;
          end
          if (rcnt_q == RCW'(RST_CYCLES)) begin
            done_q  <= grant_q;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          if (err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
          end
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant_out    = grant_q;
  assign bus.sel_out      = sel_q;
  assign bus.done_out     = done_q;
  assign bus.err_out      = err_q;
  assign bus.busy_out     = busy_q;
  assign bus.err_cnt_out  = err_cnt_q;
  assign bus.tx_start_out = tx_start_q;
  assign bus.tx_reset_out = tx_reset_q;

endmodule

// File: tb/tb_maroc_sc_scheduler.sv
// Directed bench for maroc_sc_scheduler with a behavioural MAROC transmitter model
// (PREPARE 3 cycles, SENDING 829 bits, FINAL 2 cycles; can stall or abort on demand).
module tb_maroc_sc_scheduler;
  localparam int NREQ       = 4;
  localparam int SELW       = 2;
  localparam int TIMEOUT    = 1100;
  localparam int RST_CYCLES = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // 0: normal frame, 1: stuck in PREPARE, 2: aborts to IDLE early in SENDING
  int         mode    = 0;
  logic [1:0] m_state = 2'd0;
  int         m_cnt   = 0;
  int         bits    = 0;

  always #5 clk = ~clk;

  maroc_sc_scheduler_if #(.NREQ(NREQ), .SELW(SELW)) bus ();

  maroc_sc_scheduler #(
    .NREQ(NREQ), .SELW(SELW), .TIMEOUT(TIMEOUT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk_in (clk),
    .rstn_in(rst_n),
    .bus    (bus)
  );

  assign bus.tx_state_in = m_state;

  always @(posedge clk) begin
    if (bus.tx_reset_out) begin
      m_state <= 2'd0;
      m_cnt   <= 0;
    end else begin
      case (m_state)
        2'd0: if (bus.tx_start_out) begin m_state <= 2'd1; m_cnt <= 0; end
        2'd1: if (mode != 1) begin
          if (m_cnt == 2) begin m_state <= 2'd2; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
        2'd2: begin
          bits <= bits + 1;
          if (mode == 2 && m_cnt == 1) m_state <= 2'd0;
          else if (m_cnt == 828) begin m_state <= 2'd3; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
        default: begin
          if (bus.tx_start_out) begin m_state <= 2'd1; m_cnt <= 0; end
          else if (m_cnt == 1) begin m_state <= 2'd0; m_cnt <= 0; end
          else m_cnt <= m_cnt + 1;
        end
      endcase
    end
  end

  task automatic wait_grant(input int budget, output int cyc, output int dones, output bit to);
    cyc = 0; dones = 0; to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done_out != '0) dones++;
      if (bus.grant_out != '0) begin cyc = i + 1; to = 1'b0; break; end
    end
  endtask

  task automatic wait_done(input int budget, output logic [3:0] d, output logic e,
                           output int starts, output int resets, output int cyc, output bit to);
    d = '0; e = 1'b0; starts = 0; resets = 0; cyc = 0; to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_start_out) starts++;
      if (bus.tx_reset_out) resets++;
      if (bus.done_out != '0) begin
        d = bus.done_out; e = bus.err_out; cyc = i + 1; to = 1'b0; break;
      end
    end
  endtask

  task automatic do_reset();
    bus.req_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [24:0] got;
    bus.req_in = '0;
    mode = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    got = {bus.grant_out, bus.sel_out, bus.done_out, bus.err_out, bus.busy_out,
           bus.err_cnt_out, bus.tx_start_out, bus.tx_reset_out};
    tests_run++;
    if (got !== 25'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %b expected all zero", got);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] d; logic e; int starts, resets, cyc, bits0; bit to;
    bits0 = bits;
    bus.req_in = 4'b0001;
    @(negedge clk);
    tests_run++;
    if (bus.grant_out !== 4'b0001 || bus.sel_out !== 2'd0) begin
      tests_failed++; $display("FAIL single_grant: grant %b sel %0d expected 0001 sel 0", bus.grant_out, bus.sel_out);
    end
    tests_run++;
    if (bus.tx_start_out !== 1'b1) begin
      tests_failed++; $display("FAIL single_start: tx_start %b expected 1", bus.tx_start_out);
    end
    wait_done(2000, d, e, starts, resets, cyc, to);
    bus.req_in = '0;
    tests_run++;
    if (to || d !== 4'b0001 || e !== 1'b0) begin
      tests_failed++; $display("FAIL single_done: timeout %0d done %b err %b expected done 0001 err 0", to, d, e);
    end
    tests_run++;
    if (cyc != 834 || starts != 0) begin
      tests_failed++; $display("FAIL single_latency: %0d cycles %0d extra starts expected 834 and 0", cyc, starts);
    end
    tests_run++;
    if (bits - bits0 != 829) begin
      tests_failed++; $display("FAIL single_bits: got %0d expected 829", bits - bits0);
    end
    @(negedge clk);
    tests_run++;
    if (bus.grant_out !== 4'b0000 || bus.busy_out !== 1'b0 || bus.sel_out !== 2'd0) begin
      tests_failed++; $display("FAIL single_after: grant %b busy %b sel %0d expected 0000 0 0", bus.grant_out, bus.busy_out, bus.sel_out);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] d, eg; logic e; int starts, resets, cyc, dones; bit to;
    do_reset();
    bus.req_in = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      wait_grant(2000, cyc, dones, to);
      tests_run++;
      if (to || bus.grant_out !== eg || bus.sel_out !== 2'(k % 4)) begin
        tests_failed++; $display("FAIL rr_grant%0d: grant %b sel %0d expected %b sel %0d", k, bus.grant_out, bus.sel_out, eg, k % 4);
      end
      tests_run++;
      if (cyc != ((k == 0) ? 1 : 2)) begin
        tests_failed++; $display("FAIL rr_gap%0d: got %0d cycles expected %0d", k, cyc, (k == 0) ? 1 : 2);
      end
      wait_done(2000, d, e, starts, resets, cyc, to);
      if (k == 4) bus.req_in = '0;
      tests_run++;
      if (to || d !== eg || e !== 1'b0) begin
        tests_failed++; $display("FAIL rr_done%0d: done %b err %b expected %b err 0", k, d, e, eg);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] d; logic e; int starts, resets, cyc, dones; bit to;
    bus.req_in = 4'b0100;
    wait_grant(100, cyc, dones, to);
    tests_run++;
    if (to || bus.grant_out !== 4'b0100) begin
      tests_failed++; $display("FAIL fair_first: grant %b expected 0100", bus.grant_out);
    end
    bus.req_in = 4'b0110;
    wait_done(2000, d, e, starts, resets, cyc, to);
    wait_grant(100, cyc, dones, to);
    tests_run++;
    if (to || bus.grant_out !== 4'b0010 || bus.sel_out !== 2'd1) begin
      tests_failed++; $display("FAIL fair_next: grant %b sel %0d expected 0010 sel 1", bus.grant_out, bus.sel_out);
    end
    wait_done(2000, d, e, starts, resets, cyc, to);
    bus.req_in = '0;
    tests_run++;
    if (to || d !== 4'b0010) begin
      tests_failed++; $display("FAIL fair_done: done %b expected 0010", d);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] d; logic e; int starts, resets, cyc, dones; bit to;
    mode = 1;
    bus.req_in = 4'b1000;
    wait_grant(100, cyc, dones, to);
    tests_run++;
    if (to || bus.grant_out !== 4'b1000) begin
      tests_failed++; $display("FAIL tmo_grant: grant %b expected 1000", bus.grant_out);
    end
    wait_done(1300, d, e, starts, resets, cyc, to);
    bus.req_in = '0;
    tests_run++;
    if (to || d !== 4'b1000 || e !== 1'b1) begin
      tests_failed++; $display("FAIL tmo_done: timeout %0d done %b err %b expected 1000 err 1", to, d, e);
    end
    tests_run++;
    if (resets != 4 || cyc != 1106) begin
      tests_failed++; $display("FAIL tmo_recover: tx_reset %0d cycles, done after %0d expected 4 and 1106", resets, cyc);
    end
    @(negedge clk);
    tests_run++;
    if (bus.err_cnt_out !== 8'd1) begin
      tests_failed++; $display("FAIL tmo_errcnt: got %0d expected 1", bus.err_cnt_out);
    end
    mode = 0;
  endtask

  task automatic test_ext_reset();
    logic [3:0] d; logic e; int starts, resets, cyc, dones; bit to;
    mode = 2;
    bus.req_in = 4'b0001;
    wait_grant(100, cyc, dones, to);
    wait_done(100, d, e, starts, resets, cyc, to);
    bus.req_in = '0;
    tests_run++;
    if (to || d !== 4'b0001 || e !== 1'b1 || cyc != 7) begin
      tests_failed++; $display("FAIL ext_done: done %b err %b after %0d expected 0001 err 1 after 7", d, e, cyc);
    end
    tests_run++;
    if (resets != 0) begin
      tests_failed++; $display("FAIL ext_no_recover: tx_reset %0d cycles expected 0", resets);
    end
    @(negedge clk);
    tests_run++;
    if (bus.err_cnt_out !== 8'd2) begin
      tests_failed++; $display("FAIL ext_errcnt: got %0d expected 2", bus.err_cnt_out);
    end
  endtask

  task automatic test_err_saturation();
    logic [3:0] d; logic e; int starts, resets, cyc, dones, bad; bit to, to2;
    bad = 0;
    for (int n = 3; n <= 256; n++) begin
      bus.req_in = 4'b0001;
      wait_grant(50, cyc, dones, to);
      wait_done(50, d, e, starts, resets, cyc, to2);
      bus.req_in = '0;
      if (to || to2 || e !== 1'b1) bad++;
      @(negedge clk);
      if (n == 255) begin
        tests_run++;
        if (bus.err_cnt_out !== 8'd255) begin
          tests_failed++; $display("FAIL sat_reach: got %0d expected 255", bus.err_cnt_out);
        end
      end
    end
    tests_run++;
    if (bus.err_cnt_out !== 8'd255 || bad != 0) begin
      tests_failed++; $display("FAIL sat_hold: err_cnt %0d bad transactions %0d expected 255 and 0", bus.err_cnt_out, bad);
    end
    mode = 0;
  endtask

  task automatic test_reset_mid_send();
    logic [3:0] d; logic e; int starts, resets, cyc, dones; bit to;
    logic [24:0] got;
    bus.req_in = 4'b0100;
    wait_grant(100, cyc, dones, to);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {bus.grant_out, bus.sel_out, bus.done_out, bus.err_out, bus.busy_out,
           bus.err_cnt_out, bus.tx_start_out, bus.tx_reset_out};
    tests_run++;
    if (got !== 25'd0) begin
      tests_failed++; $display("FAIL midrst_outputs: got %b expected all zero", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_in = 4'b0101;
    wait_grant(1500, cyc, dones, to);
    tests_run++;
    if (to || dones != 0 || bus.grant_out !== 4'b0001) begin
      tests_failed++; $display("FAIL midrst_regrant: grant %b stray dones %0d expected 0001 and 0", bus.grant_out, dones);
    end
    wait_done(2000, d, e, starts, resets, cyc, to);
    bus.req_in = '0;
    tests_run++;
    if (to || d !== 4'b0001 || e !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_done: done %b err %b expected 0001 err 0", d, e);
    end
  endtask

  initial begin
    bus.req_in = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_timeout();
    test_ext_reset();
    test_err_saturation();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/maroc_sc_scheduler.md
# maroc_sc_scheduler

Arbiter and sequencer for the shared MAROC slow-control `transmitter`. Up to NREQ requesters (host register bank, power-up default loader, calibration engine, …) each own one configuration frame source. The block grants the transmitter to one requester at a time, round-robin, and drives the frame-source select. It pulses the transmitter start, tracks completion through the transmitter `state_out`, and recovers the transmitter on timeout.

## Interface

**Parameters**
- `NREQ`, 4: number of requesters.
- `SELW`, 2: width of `sel_out`; equals clog2(NREQ).
- `TIMEOUT`, 1100: maximum cycles from start pulse to FINAL. Must exceed 829 frame bits plus overhead.
- `RST_CYCLES`, 4: width of the recovery reset pulse.

**Ports**
- `clk_in`  in  1  5 MHz slow-control clock, same clock as the transmitter.
- `rstn_in`  in  1  asynchronous, active-low reset.
- `req_in`  in  NREQ  level request per requester. Held until that requester's `done_out`.
- `grant_out`  out  NREQ  one-hot grant. Held from grant until `done_out`.
- `sel_out`  out  SELW  binary index of the granted requester. Drives the frame mux into the transmitter data inputs.
- `done_out`  out  NREQ  one-cycle completion pulse to the granted requester.
- `err_out`  out  1  one-cycle pulse, coincident with `done_out`, when the transaction failed.
- `busy_out`  out  1  high in every state except IDLE.
- `err_cnt_out`  out  8  saturating count of failed transactions.
- `tx_start_out`  out  1  to transmitter `start_in`.
- `tx_reset_out`  out  1  to transmitter `reset_in` (active-high).
- `tx_state_in`  in  2  from transmitter `state_out`. Encoding: 0 IDLE, 1 PREPARE, 2 SENDING, 3 FINAL.

## Operation

**Reset values.** All outputs are 0. The state machine is in IDLE. The round-robin pointer `last` is NREQ-1, so requester 0 has first priority. The timeout counter is 0.

**States.**
- **IDLE**
  - Leave only if `req_in` is non-zero and `tx_state_in` is 0 or 3. Otherwise stay.
  - On leaving, grant the first requesting index found by scanning upward from `last+1`, modulo NREQ.
  - Register `grant_out`, `sel_out` and `last`, then go to START.
- **START**
  - `tx_start_out` = 1 for exactly this cycle. `sel_out` is already stable.
  - Clear the timeout counter. Go to WAIT_SEND.
- **WAIT_SEND**
  - `tx_state_in` == 2: go to WAIT_FINAL.
  - Counter reaches TIMEOUT-1: go to RECOVER.
- **WAIT_FINAL**
  - `tx_state_in` == 3: go to DONE with error flag clear.
  - `tx_state_in` == 0 (transmitter reset externally): go to DONE with error flag set. No recovery.
  - Counter reaches TIMEOUT-1: go to RECOVER.
- **RECOVER**
  - `tx_reset_out` = 1 for RST_CYCLES cycles, then 0 for one cycle.
  - Go to DONE with error flag set.
- **DONE**
  - `done_out[granted]` = 1.
  - `err_out` equals the error flag. If the flag is set, increment `err_cnt_out`, saturating at 255.
  - Clear `grant_out`. Go to IDLE.

**Rules.**
- `req_in` is sampled only in IDLE. Changes to `req_in` while granted are ignored.
- `sel_out` holds its value after DONE, until the next grant.
- The timeout counter is 11 bits and counts every cycle in WAIT_SEND and WAIT_FINAL.
- Fairness: a requester that keeps `req_in` high through DONE is not re-granted while any other requester is requesting.
- Only one transaction is in flight. `tx_start_out` is never asserted while `busy_out` shows a prior transaction.

## Timing

- `req_in` rises at cycle t while in IDLE with transmitter idle:
  - `grant_out` and `sel_out` are valid at t+1.
  - `tx_start_out` is high during t+1.
  - The transmitter latches frame data at the end of t+1. `sel_out` must be stable then, and it is held longer.
- `done_out` rises one cycle after the first cycle in which WAIT_FINAL observes `tx_state_in` == 3. Nominal transaction length is about 835 cycles.
- Back-to-back transactions: at least 2 idle cycles between a `done_out` and the next `tx_start_out` (DONE, then IDLE).
- Timeout path: `done_out`/`err_out` arrive TIMEOUT + RST_CYCLES + 2 cycles after START.
- `rstn_in` low mid-transaction:
  - `tx_start_out`, `tx_reset_out`, `grant_out` and `done_out` drop to 0 immediately (asynchronous).
  - No `done_out` is issued for the aborted transaction.
  - `err_cnt_out` clears to 0.

## Test plan

1. **Single request.** `req_in` = 0001 with the transmitter model idle.
   - `grant_out` = 0001 and `sel_out` = 0 at t+1.
   - One `tx_start_out` pulse.
   - One `done_out[0]` pulse with `err_out` = 0 after FINAL.
   - Exactly 829 serial bits observed.
2. **Round robin.** `req_in` = 1111 held continuously.
   - Grant order is 0, 1, 2, 3, 0.
   - Each grant follows its predecessor's `done_out`.
   - `sel_out` matches the grant every time.
3. **Fairness.** Requester 2 keeps `req_in` high after its `done_out` while requester 1 is also requesting.
   - Next grant = 1, never 2 twice in a row.
4. **Timeout.** Transmitter model stuck in PREPARE.
   - After TIMEOUT cycles, `tx_reset_out` is high for 4 cycles.
   - `done_out` and `err_out` pulse together.
   - `err_cnt_out` = 1.
   - After 256 failures, `err_cnt_out` stays at 255.
5. **External transmitter reset.** `tx_state_in` forced to 0 during WAIT_FINAL.
   - `done_out` with `err_out` = 1.
   - `tx_reset_out` never asserted.
6. **Reset mid-send.** `rstn_in` pulsed low during WAIT_FINAL.
   - All outputs are 0 in the same cycle.
   - No `done_out`.
   - The next request is granted to requester 0 first.
